// File: rtl/dir_offset_seq.sv
// dir_offset_seq: walks a WIN x WIN sampling window in raster order and streams
// signed (dx,dy) offsets relative to the window centre over valid/ready.
// Optional feature: define DIR_OFFSET_ROT_EN to add a quad[1:0] input that rotates
// the offsets by quad*90 degrees (quad is latched on an accepted start).
module dir_offset_seq #(
    parameter int WIN = 16,
    parameter int OW  = 5,
    localparam int LW = $clog2(WIN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
`ifdef DIR_OFFSET_ROT_EN
    input  logic [1:0]      quad,
`endif
    output logic            busy,
    output logic            done,
    output logic            off_valid,
    input  logic            off_ready,
    output logic [OW-1:0]   dx,
    output logic [OW-1:0]   dy,
    output logic [2*LW-1:0] idx,
    output logic            last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // WIN is a power of two, so the final index is all ones.
    localparam logic [2*LW-1:0] IDX_ONE  = {{(2*LW-1){1'b0}}, 1'b1};
    localparam logic [2*LW-1:0] LAST_IDX = '1;
    localparam logic [OW-1:0]   HALF     = OW'(WIN / 2);

    state_t          state;
    logic [2*LW-1:0] load_idx;
    logic [LW-1:0]   col;
    logic [LW-1:0]   row;
    logic [OW-1:0]   raw_dx;
    logic [OW-1:0]   raw_dy;
    logic [OW-1:0]   next_dx;
    logic [OW-1:0]   next_dy;
    logic            load_last;
    logic            handshake;
`ifdef DIR_OFFSET_ROT_EN
    logic [1:0]      quad_reg;
    logic [1:0]      rot_sel;
`endif

    assign handshake = off_valid && off_ready;

    // Next output word: index 0 when launching from IDLE, otherwise the successor.
    // Offsets (and rotation) are formed here so they land in the output register
    // with no extra pipeline stage.
    always_comb begin
        load_idx  = (state == IDLE) ? '0 : idx + IDX_ONE;
        col       = load_idx[LW-1:0];
        row       = load_idx[2*LW-1:LW];
        raw_dx    = {{(OW-LW){1'b0}}, col} - HALF;
        raw_dy    = {{(OW-LW){1'b0}}, row} - HALF;
        load_last = (load_idx == LAST_IDX);
        next_dx   = raw_dx;
        next_dy   = raw_dy;
`ifdef DIR_OFFSET_ROT_EN
        // A fresh walk uses the quad presented with start; later words use the latched copy.
        rot_sel = (state == IDLE) ? quad : quad_reg;
        case (rot_sel)
            2'd1: begin next_dx = -raw_dy; next_dy =  raw_dx; end
            2'd2: begin next_dx = -raw_dx; next_dy = -raw_dy; end
            2'd3: begin next_dx =  raw_dy; next_dy = -raw_dx; end
            default: begin next_dx = raw_dx; next_dy = raw_dy; end
        endcase
`endif
    end

    // Walk sequencer with registered outputs; abort takes priority over a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            off_valid <= 1'b0;
            last      <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            idx       <= '0;
`ifdef DIR_OFFSET_ROT_EN
            quad_reg  <= 2'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        off_valid <= 1'b1;
                        idx       <= load_idx;
                        dx        <= next_dx;
                        dy        <= next_dy;
                        last      <= load_last;
`ifdef DIR_OFFSET_ROT_EN
                        quad_reg  <= quad;
`endif
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        off_valid <= 1'b0;
                        last      <= 1'b0;
                    end else if (handshake) begin
                        if (last) begin
                            state     <= FINISH;
                            busy      <= 1'b0;
                            off_valid <= 1'b0;
                            last      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx  <= load_idx;
                            dx   <= next_dx;
                            dy   <= next_dy;
                            last <= load_last;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
